// File: rtl/line_mem_responder_pkg.sv
// Shared types for the line-granular memory responder: line/address widths,
// FSM state encoding and line alignment helper.
package line_mem_responder_pkg;

  localparam int LINE_BITS        = 128;
  localparam int LINE_OFFSET_BITS = 4;
  localparam int ADDR_BITS        = 32;
  localparam int CNT_BITS         = 8;

  typedef logic [LINE_BITS-1:0] line_t;
  typedef logic [ADDR_BITS-1:0] addr_t;

  typedef enum logic [1:0] {
    MEMR_IDLE,
    MEMR_WAIT,
    MEMR_RESP
  } memr_state_t;

  function automatic addr_t line_align(addr_t a);
    return a & ~addr_t'((1 << LINE_OFFSET_BITS) - 1);
  endfunction

endpackage

// File: rtl/line_mem_responder_if.sv
// Request/response channel between the data cache (master) and the
// line memory responder (slave).
interface line_mem_responder_if;
  import line_mem_responder_pkg::*;

  logic  req_valid_i;
  logic  req_ready_o;
  addr_t req_addr_i;
  logic  req_we_i;
  line_t req_data_i;
  logic  rsp_valid_o;
  logic  rsp_ready_i;
  line_t rsp_data_o;
  addr_t rsp_addr_o;

  modport slave (
    input  req_valid_i, req_addr_i, req_we_i, req_data_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, rsp_addr_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_we_i, req_data_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_addr_o
  );

endinterface

// File: rtl/line_mem_responder_array.sv
// Single-port line storage: one write or one registered read per cycle.
// Only the read register is reset; the array contents are not.
module line_mem_responder_array
  import line_mem_responder_pkg::*;
#(
  parameter int    DEPTH_LINES = 1024,
  parameter string INIT_FILE   = "",
  localparam int   IDX_BITS    = $clog2(DEPTH_LINES)
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic                i_wr_en,
  input  logic                i_rd_en,
  input  logic [IDX_BITS-1:0] i_idx,
  input  line_t               i_wr_data,
  output line_t               o_rd_data
);

  line_t r_mem [DEPTH_LINES];
  line_t r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_idx] <= i_wr_data;
    end
  end

  // Read register holds its value between reads so the response stays frozen
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_idx];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/line_mem_responder.sv
// Memory-side responder for line refills/write-throughs: writes complete in
// one cycle with no response; reads return the line after LATENCY cycles.
module line_mem_responder
  import line_mem_responder_pkg::*;
#(
  parameter int    DEPTH_LINES = 1024,
  parameter int    LATENCY     = 4,
  parameter string INIT_FILE   = ""
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  line_mem_responder_if.slave  bus
);

  localparam int                IDX_BITS = $clog2(DEPTH_LINES);
  localparam logic [CNT_BITS-1:0] LAT_M1 = CNT_BITS'(LATENCY - 1);

  memr_state_t         r_state;
  memr_state_t         w_state_nxt;
  logic [CNT_BITS-1:0] r_cnt;
  logic [CNT_BITS-1:0] w_cnt_nxt;
  addr_t               r_cap_addr;
  addr_t               w_cap_addr_nxt;
  addr_t               r_rsp_addr;
  addr_t               w_req_line_addr;
  addr_t               w_mem_addr;
  logic                w_wr_en;
  logic                w_rd_en;
  logic [IDX_BITS-1:0] w_idx;
  line_t               w_rd_data;

  assign w_req_line_addr = line_align(bus.req_addr_i);

  // In IDLE the array is addressed by the live request; afterwards by the captured read
  assign w_mem_addr = (r_state == MEMR_IDLE) ? w_req_line_addr : r_cap_addr;
  assign w_idx      = w_mem_addr[LINE_OFFSET_BITS +: IDX_BITS];

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_state    <= MEMR_IDLE;
      r_cnt      <= '0;
      r_cap_addr <= '0;
      r_rsp_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_cap_addr <= w_cap_addr_nxt;
      if (w_rd_en) begin
        r_rsp_addr <= w_mem_addr;
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_cap_addr_nxt = r_cap_addr;
    w_wr_en        = 1'b0;
    w_rd_en        = 1'b0;
    case (r_state)
      MEMR_IDLE: begin
        if (bus.req_valid_i) begin
          if (bus.req_we_i) begin
            w_wr_en = 1'b1;
          end else begin
            w_cap_addr_nxt = w_req_line_addr;
            w_cnt_nxt      = LAT_M1;
            if (LATENCY == 1) begin
              w_state_nxt = MEMR_RESP;
              w_rd_en     = 1'b1;
            end else begin
              w_state_nxt = MEMR_WAIT;
            end
          end
        end
      end
      MEMR_WAIT: begin
        w_cnt_nxt = r_cnt - 1'b1;
        // Reading on the edge that enters RESP lands the data with rsp_valid_o
        if (r_cnt == 1) begin
          w_state_nxt = MEMR_RESP;
          w_rd_en     = 1'b1;
        end
      end
      MEMR_RESP: begin
        if (bus.rsp_ready_i) begin
          w_state_nxt = MEMR_IDLE;
        end
      end
      default: begin
        w_state_nxt = MEMR_IDLE;
      end
    endcase
  end

  line_mem_responder_array #(
    .DEPTH_LINES (DEPTH_LINES),
    .INIT_FILE   (INIT_FILE)
  ) u_array (
    .i_clk     (clk_i),
    .i_rstn    (rstn_i),
    .i_wr_en   (w_wr_en),
    .i_rd_en   (w_rd_en),
    .i_idx     (w_idx),
    .i_wr_data (bus.req_data_i),
    .o_rd_data (w_rd_data)
  );

  assign bus.req_ready_o = (r_state == MEMR_IDLE);
  assign bus.rsp_valid_o = (r_state == MEMR_RESP);
  assign bus.rsp_data_o  = w_rd_data;
  assign bus.rsp_addr_o  = r_rsp_addr;

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed bench for line_mem_responder: one instance with LATENCY=4 and one
// with LATENCY=1, both with 16 lines so address aliasing is reachable.
module tb_line_mem_responder;
  import line_mem_responder_pkg::*;

  logic clk;
  logic rstn;
  int   n_checks;
  int   n_fail;

  line_mem_responder_if if0();
  line_mem_responder_if if1();

  line_mem_responder #(.DEPTH_LINES(16), .LATENCY(4), .INIT_FILE("")) u_dut0 (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (if0)
  );

  line_mem_responder #(.DEPTH_LINES(16), .LATENCY(1), .INIT_FILE("")) u_dut1 (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  line_t line_a;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int which, input addr_t a, input line_t d);
    if (which == 0) begin
      if0.req_valid_i = 1'b1; if0.req_we_i = 1'b1; if0.req_addr_i = a; if0.req_data_i = d;
    end else begin
      if1.req_valid_i = 1'b1; if1.req_we_i = 1'b1; if1.req_addr_i = a; if1.req_data_i = d;
    end
    tick();
    if0.req_valid_i = 1'b0; if0.req_we_i = 1'b0;
    if1.req_valid_i = 1'b0; if1.req_we_i = 1'b0;
  endtask

  // Issues a read, returns edges from accept (inclusive) until rsp_valid_o seen, then consumes it
  task automatic rd(input int which, input addr_t a, output int lat, output line_t d, output addr_t ra);
    if (which == 0) begin
      if0.req_valid_i = 1'b1; if0.req_we_i = 1'b0; if0.req_addr_i = a;
    end else begin
      if1.req_valid_i = 1'b1; if1.req_we_i = 1'b0; if1.req_addr_i = a;
    end
    tick();
    if0.req_valid_i = 1'b0;
    if1.req_valid_i = 1'b0;
    lat = 1;
    while (!((which == 0) ? if0.rsp_valid_o : if1.rsp_valid_o) && lat < 20) begin
      tick();
      lat++;
    end
    d  = (which == 0) ? if0.rsp_data_o : if1.rsp_data_o;
    ra = (which == 0) ? if0.rsp_addr_o : if1.rsp_addr_o;
    if0.rsp_ready_i = (which == 0);
    if1.rsp_ready_i = (which != 0);
    tick();
    if0.rsp_ready_i = 1'b0;
    if1.rsp_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    tick();
    tick();
    n_checks++;
    if (if0.req_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready0 got %b want 1", if0.req_ready_o);
    end
    n_checks++;
    if (if0.rsp_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid0 got %b want 0", if0.rsp_valid_o);
    end
    n_checks++;
    if (if0.rsp_data_o !== '0) begin
      n_fail++; $display("FAIL reset_data0 got %h want 0", if0.rsp_data_o);
    end
    n_checks++;
    if (if0.rsp_addr_o !== '0) begin
      n_fail++; $display("FAIL reset_addr0 got %h want 0", if0.rsp_addr_o);
    end
    n_checks++;
    if (if1.req_ready_o !== 1'b1 || if1.rsp_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_dut1 got ready=%b valid=%b want 1/0", if1.req_ready_o, if1.rsp_valid_o);
    end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    int    lat;
    line_t d;
    addr_t ra;
    wr(0, 32'h0000_0040, line_a);
    n_checks++;
    if (if0.req_ready_o !== 1'b1 || if0.rsp_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL wr_no_rsp got ready=%b valid=%b want 1/0", if0.req_ready_o, if0.rsp_valid_o);
    end
    rd(0, 32'h0000_004C, lat, d, ra);
    n_checks++;
    if (lat !== 4) begin
      n_fail++; $display("FAIL rd_latency got %0d want 4", lat);
    end
    n_checks++;
    if (d !== line_a) begin
      n_fail++; $display("FAIL rd_data got %h want %h", d, line_a);
    end
    n_checks++;
    if (ra !== 32'h0000_0040) begin
      n_fail++; $display("FAIL rd_addr got %h want 00000040", ra);
    end
    n_checks++;
    if (if0.req_ready_o !== 1'b1 || if0.rsp_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL rd_done got ready=%b valid=%b want 1/0", if0.req_ready_o, if0.rsp_valid_o);
    end
  endtask

  task automatic test_backpressure();
    int    waited;
    line_t d;
    addr_t ra;
    int    lat;
    wr(0, 32'h0000_0050, line_t'(128'h5555));
    if0.req_valid_i = 1'b1; if0.req_we_i = 1'b0; if0.req_addr_i = 32'h0000_0048;
    tick();
    // Valid stays high with a write that must not be accepted while busy
    if0.req_we_i = 1'b1; if0.req_addr_i = 32'h0000_0050; if0.req_data_i = line_t'(128'hBAD);
    waited = 0;
    while (!if0.rsp_valid_o && waited < 20) begin
      n_checks++;
      if (if0.req_ready_o !== 1'b0) begin
        n_fail++; $display("FAIL bp_wait_ready got %b want 0", if0.req_ready_o);
      end
      tick();
      waited++;
    end
    n_checks++;
    if (waited !== 3) begin
      n_fail++; $display("FAIL bp_latency got %0d extra cycles want 3", waited);
    end
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (if0.rsp_valid_o !== 1'b1 || if0.req_ready_o !== 1'b0 ||
          if0.rsp_data_o !== line_a || if0.rsp_addr_o !== 32'h0000_0040) begin
        n_fail++;
        $display("FAIL bp_hold cyc %0d got valid=%b ready=%b addr=%h data=%h want 1/0/00000040/%h",
                 i, if0.rsp_valid_o, if0.req_ready_o, if0.rsp_addr_o, if0.rsp_data_o, line_a);
      end
      tick();
    end
    if0.rsp_ready_i = 1'b1;
    tick();
    if0.rsp_ready_i = 1'b0;
    if0.req_valid_i = 1'b0;
    if0.req_we_i    = 1'b0;
    n_checks++;
    if (if0.req_ready_o !== 1'b1 || if0.rsp_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL bp_release got ready=%b valid=%b want 1/0", if0.req_ready_o, if0.rsp_valid_o);
    end
    rd(0, 32'h0000_0050, lat, d, ra);
    n_checks++;
    if (d !== line_t'(128'h5555)) begin
      n_fail++; $display("FAIL bp_no_accept got %h want 5555", d);
    end
  endtask

  task automatic test_alias();
    int    lat;
    line_t d;
    addr_t ra;
    wr(0, 32'h0000_0010, line_t'(128'h1));
    rd(0, 32'h0000_0110, lat, d, ra);
    n_checks++;
    if (d !== line_t'(128'h1)) begin
      n_fail++; $display("FAIL alias_data got %h want 1", d);
    end
    n_checks++;
    if (ra !== 32'h0000_0110) begin
      n_fail++; $display("FAIL alias_addr got %h want 00000110", ra);
    end
  endtask

  task automatic test_back_to_back();
    int    lat;
    line_t d;
    addr_t ra;
    line_t exp;
    for (int i = 0; i < 4; i++) begin
      if1.req_valid_i = 1'b1;
      if1.req_we_i    = 1'b1;
      if1.req_addr_i  = addr_t'(i * 16);
      if1.req_data_i  = {4{32'h1000_0000 + 32'(i)}};
      n_checks++;
      if (if1.req_ready_o !== 1'b1) begin
        n_fail++; $display("FAIL b2b_ready line %0d got %b want 1", i, if1.req_ready_o);
      end
      tick();
    end
    if1.req_valid_i = 1'b0;
    if1.req_we_i    = 1'b0;
    n_checks++;
    if (if1.req_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL b2b_ready_end got %b want 1", if1.req_ready_o);
    end
    for (int i = 0; i < 4; i++) begin
      rd(1, addr_t'(i * 16 + 4), lat, d, ra);
      exp = {4{32'h1000_0000 + 32'(i)}};
      n_checks++;
      if (lat !== 1 || d !== exp || ra !== addr_t'(i * 16)) begin
        n_fail++;
        $display("FAIL lat1_read line %0d got lat=%0d addr=%h data=%h want 1/%h/%h",
                 i, lat, ra, d, addr_t'(i * 16), exp);
      end
    end
  endtask

  task automatic test_mid_reset();
    int    lat;
    line_t d;
    addr_t ra;
    if0.req_valid_i = 1'b1; if0.req_we_i = 1'b0; if0.req_addr_i = 32'h0000_0040;
    tick();
    if0.req_valid_i = 1'b0;
    tick();
    // WAIT with counter at 2: reset lands before the RESP transition
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (if0.rsp_valid_o !== 1'b0 || if0.req_ready_o !== 1'b1) begin
        n_fail++; $display("FAIL midrst cyc %0d got valid=%b ready=%b want 0/1", i, if0.rsp_valid_o, if0.req_ready_o);
      end
      tick();
    end
    rd(0, 32'h0000_0040, lat, d, ra);
    n_checks++;
    if (lat !== 4 || d !== line_a) begin
      n_fail++; $display("FAIL midrst_reread4 got lat=%0d data=%h want 4/%h", lat, d, line_a);
    end
    rd(0, 32'h0000_0010, lat, d, ra);
    n_checks++;
    if (d !== line_t'(128'h1)) begin
      n_fail++; $display("FAIL midrst_reread1 got %h want 1", d);
    end
    rd(1, 32'h0000_0020, lat, d, ra);
    n_checks++;
    if (d !== {4{32'h1000_0002}}) begin
      n_fail++; $display("FAIL midrst_dut1 got %h want %h", d, {4{32'h1000_0002}});
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    line_a   = {32'h0000_DDDD, 32'h0000_CCCC, 32'h0000_BBBB, 32'h0000_AAAA};
    rstn     = 1'b0;
    if0.req_valid_i = 1'b0; if0.req_we_i = 1'b0; if0.req_addr_i = '0; if0.req_data_i = '0; if0.rsp_ready_i = 1'b0;
    if1.req_valid_i = 1'b0; if1.req_we_i = 1'b0; if1.req_addr_i = '0; if1.req_data_i = '0; if1.rsp_ready_i = 1'b0;
    test_reset();
    test_write_read();
    test_backpressure();
    test_alias();
    test_back_to_back();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
